// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the seq_det detector
// Contents: clog2 for port widths, reset-default configuration, len-to-mask helper.
package seq_det_pkg;

    // Widest pattern the mask helper can describe; MAX_LEN must not exceed it.
    localparam int PAT_W_MAX = 64;

    localparam logic [PAT_W_MAX-1:0] DEF_PAT_C = 64'b1110010;
    localparam int                   DEF_LEN_C = 7;
    localparam bit                   DEF_OVL_C = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Low len bits set; callers truncate to their pattern width.
    function automatic logic [PAT_W_MAX-1:0] len_mask(input int len);
        logic [PAT_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating up-counter with clear and increment enable
// Ports: clk, rst_n (sync, active-low), clr (sync clear), inc (count enable), cnt (value).
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det.sv
// rtl/seq_det.sv - programmable serial bit-pattern detector with match counter
// Ports: clk, rst_n (sync, active-low); cfg_we/cfg_pat/cfg_len/cfg_ovl load a new
// configuration; in_vld/in carry the serial stream; out is the registered match
// pulse, match_cnt the saturating match count, state the valid-bit fill count.
module seq_det
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 16,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(DEF_PAT_C),
    parameter int                 DEF_LEN = DEF_LEN_C,
    parameter bit                 DEF_OVL = DEF_OVL_C,
    localparam int                LEN_W   = clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               in_vld,
    input  logic               in,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   state
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_n;
    logic               ovl_q;
    logic               hit;

    assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // Newest bit enters at bit 0, so after len beats the first bit sits at [len-1].
    assign hist_n = {hist[MAX_LEN-2:0], in};

    // Saturate explicitly: MAX_LEN+1 need not fit in LEN_W bits.
    assign fill_n = (fill == LEN_MAX) ? fill : fill + 1'b1;

    assign mask = MAX_LEN'(len_mask(32'(len_q)));

    // The fill gate keeps stale history (pre-load or pre-restart bits) out of a match.
    assign hit = (len_q != '0) && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            out   <= 1'b0;
            pat_q <= DEF_PAT;
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVL;
        end else if (cfg_we) begin
            hist  <= '0;
            fill  <= '0;
            out   <= 1'b0;
            pat_q <= cfg_pat;
            len_q <= len_clamped;
            ovl_q <= cfg_ovl;
        end else if (in_vld) begin
            hist <= hist_n;
            out  <= hit;
            // Non-overlapping: the next match must be built from len fresh bits.
            fill <= (hit && !ovl_q) ? '0 : fill_n;
        end else begin
            out <= 1'b0;
        end
    end

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg_we),
        .inc   (in_vld && !cfg_we && hit),
        .cnt   (match_cnt)
    );

    assign state = fill;

endmodule

// File: tb/tb_seq_det.sv
// tb/tb_seq_det.sv - self-checking bench for seq_det against a bit-list reference model
module tb_seq_det;

    localparam int ML = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [15:0] cfg_pat;
    logic [4:0]  cfg_len;
    logic        cfg_ovl;
    logic        in_vld;
    logic        in_b;

    logic        out1;
    logic [7:0]  cnt1;
    logic [4:0]  st1;
    logic        out2;
    logic [1:0]  cnt2;
    logic [4:0]  st2;

    int nvec = 0;
    int nerr = 0;

    // Reference model: every valid bit since the last clear, plus where the
    // current match attempt started (moves forward after a non-overlapping hit).
    int          q[$];
    int          start;
    logic [15:0] m_pat;
    int          m_len;
    bit          m_ovl;
    int          n_match;
    bit          m_out;

    always #5 clk = ~clk;

    seq_det u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .in_vld(in_vld), .in(in_b), .out(out1), .match_cnt(cnt1), .state(st1)
    );

    seq_det #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .in_vld(in_vld), .in(in_b), .out(out2), .match_cnt(cnt2), .state(st2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_clear();
        q.delete();
        start   = 0;
        n_match = 0;
        m_out   = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit we, input logic [15:0] p, input int l,
                              input bit o, input bit v, input bit b);
        bit ok;
        if (r) begin
            model_clear();
            m_pat = 16'b1110010;
            m_len = 7;
            m_ovl = 1'b1;
        end else if (we) begin
            model_clear();
            m_pat = p;
            m_len = (l > ML) ? ML : l;
            m_ovl = o;
        end else if (v) begin
            q.push_back(int'(b));
            ok = (m_len != 0) && ((q.size() - start) >= m_len);
            for (int k = 0; k < m_len; k++) begin
                if (ok && (q[q.size() - 1 - k] != int'(m_pat[k]))) ok = 1'b0;
            end
            m_out = ok;
            if (ok) begin
                n_match++;
                if (!m_ovl) start = q.size();
            end
        end else begin
            m_out = 1'b0;
        end
    endtask

    task automatic cyc(input bit r, input bit we, input logic [15:0] p, input int l,
                       input bit o, input bit v, input bit b);
        int f;
        rst_n   = !r;
        cfg_we  = we;
        cfg_pat = p;
        cfg_len = 5'(l);
        cfg_ovl = o;
        in_vld  = v;
        in_b    = b;
        @(posedge clk);
        model_step(r, we, p, l, o, v, b);
        #1;
        f = sat(q.size() - start, ML);
        chk("out", 32'(out1), 32'(m_out));
        chk("out_w2", 32'(out2), 32'(m_out));
        chk("cnt", 32'(cnt1), 32'(sat(n_match, 255)));
        chk("cnt_w2", 32'(cnt2), 32'(sat(n_match, 3)));
        chk("state", 32'(st1), 32'(f));
        chk("state_w2", 32'(st2), 32'(f));
        @(negedge clk);
    endtask

    task automatic do_rst();
        cyc(1'b1, 1'b0, 16'h0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beat(input bit b);
        cyc(1'b0, 1'b0, 16'h0, 0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [15:0] p, input int l, input bit o);
        cyc(1'b0, 1'b1, p, l, o, 1'b0, 1'b0);
    endtask

    task automatic send_default_prefix(input int n);
        logic [6:0] d;
        d = 7'b1110010;
        for (int i = 0; i < n; i++) beat(d[6 - i]);
    endtask

    initial begin
        int seen;
        int r;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0;
        cfg_ovl = 1'b0; in_vld = 1'b0; in_b = 1'b0;
        model_clear();
        m_pat = 16'b1110010; m_len = 7; m_ovl = 1'b1;
        @(negedge clk);

        // Reset state and default 1110010 detection.
        do_rst();
        chk("rst_out", 32'(out1), 0);
        chk("rst_cnt", 32'(cnt1), 0);
        send_default_prefix(7);
        chk("dflt_pulse", 32'(out1), 1);
        chk("dflt_cnt", 32'(cnt1), 1);
        chk("dflt_state", 32'(st1), 7);
        idle();
        chk("dflt_single", 32'(out1), 0);

        // 101 overlapping, then non-overlapping.
        load(16'b101, 3, 1'b1);
        beat(1); beat(0); beat(1); beat(0); beat(1);
        chk("ovl_cnt", 32'(cnt1), 2);
        load(16'b101, 3, 1'b0);
        beat(1); beat(0); beat(1); beat(0); beat(1);
        chk("novl_cnt", 32'(cnt1), 1);
        chk("novl_state", 32'(st1), 2);

        // Gaps between valid beats.
        do_rst();
        for (int i = 0; i < 7; i++) begin
            send_default_prefix(0);
            beat(i == 0 || i == 1 || i == 2 || i == 5);
            if (i < 6) begin idle(); idle(); idle(); end
        end
        chk("gap_cnt", 32'(cnt1), 1);

        // Saturation of the narrow counter.
        load(16'b11, 2, 1'b1);
        for (int i = 0; i < 8; i++) beat(1);
        chk("sat_cnt8", 32'(cnt1), 7);
        chk("sat_cnt2", 32'(cnt2), 3);
        chk("sat_pulse", 32'(out2), 1);

        // Reset mid-pattern.
        do_rst();
        send_default_prefix(6);
        do_rst();
        beat(0);
        chk("midrst_out", 32'(out1), 0);
        chk("midrst_state", 32'(st1), 1);

        // Config load colliding with a beat.
        do_rst();
        send_default_prefix(3);
        cyc(1'b0, 1'b1, 16'b1110010, 7, 1'b1, 1'b1, 1'b0);
        beat(0); beat(1); beat(0);
        chk("midcfg_cnt", 32'(cnt1), 0);

        // Length zero never matches.
        load(16'h0000, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            beat(1'($urandom_range(0, 1)));
            if (out1) seen++;
        end
        chk("len0_quiet", 32'(seen), 0);

        // Oversized length clamps to the full width.
        load(16'hFFFF, ML + 3, 1'b1);
        for (int i = 0; i < 15; i++) beat(1);
        chk("clamp_early", 32'(out1), 0);
        beat(1);
        chk("clamp_pulse", 32'(out1), 1);
        chk("clamp_state", 32'(st1), ML);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_rst();
            end else if (r < 4) begin
                load(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19))
                                                                : int'($urandom_range(1, 4)),
                     1'($urandom_range(0, 1)));
            end else begin
                cyc(1'b0, 1'b0, 16'h0, 0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_det.md
# seq_det

Parametrised serial bit-pattern detector for the FSM block family. It generalises the fixed 7-bit detector (pattern 1110010) to a runtime-programmable pattern of up to MAX_LEN bits, and adds:

- an input qualifier;
- selectable overlapping or non-overlapping detection;
- a saturating match counter.

It sits on a serial bit stream and emits a one-cycle match pulse to downstream control logic.

## Interface
Parameters:
- MAX_LEN, 16, maximum pattern length in bits (≥2)
- CNT_W, 8, width of the match counter
- DEF_PAT, 16'b1110010, pattern loaded at reset (LSB-aligned)
- DEF_LEN, 7, pattern length loaded at reset
- DEF_OVL, 1, overlap mode loaded at reset

Ports (LEN_W = clog2(MAX_LEN+1)):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  load cfg_pat/cfg_len/cfg_ovl this cycle
- cfg_pat  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length; 0 disables detection; values > MAX_LEN are clamped to MAX_LEN
- cfg_ovl  in  1  1 = overlapping matches, 0 = non-overlapping
- in_vld  in  1  the in bit is valid this cycle
- in  in  1  serial data bit
- out  out  1  match pulse, registered
- match_cnt  out  CNT_W  saturating count of matches
- state  out  LEN_W  fill count: valid bits accumulated toward a match, saturating at MAX_LEN

## Operation
Registers:
- hist[MAX_LEN-1:0]: shift history
- fill: fill count
- pat, len, ovl: active configuration
- out, match_cnt: outputs

Reset (rst_n=0 at a clock edge):
- hist=0, fill=0, out=0, match_cnt=0
- pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL

Config load (cfg_we=1):
- Load pat/len (clamped)/ovl.
- Clear hist, fill, out and match_cnt.
- Any in_vld beat in the same cycle is dropped; cfg_we wins.

Input beat (in_vld=1, cfg_we=0):
- hist_n = {hist[MAX_LEN-2:0], in}
- fill_n = min(fill+1, MAX_LEN)
- hit = (len≠0) && (fill_n ≥ len) && ((hist_n ^ pat) & mask) == 0, where mask = the low len bits set
- On hit:
  - out←1
  - match_cnt←match_cnt+1, saturating at 2^CNT_W−1
  - fill←fill_n if ovl=1, else fill←0 (the next match needs len fresh bits)
- On miss: out←0, fill←fill_n.
- hist←hist_n in both cases.

Idle (in_vld=0, cfg_we=0):
- hist, fill and match_cnt hold; out←0.

Equivalence: overlap mode is equivalent to a KMP automaton. The default configuration reproduces the 1110010 detector's behaviour, including restarting on trailing bits.

## Timing
- Latency: out is high exactly the one cycle following the clock edge that samples the completing beat. It is never high for two cycles from one beat.
- match_cnt and state update on the same edge as out.
- Back-to-back beats are accepted every cycle; there is no backpressure.
- Gaps in in_vld do not break a partial match; only valid beats count.
- Reset or cfg_we mid-pattern:
  - Partially shifted bits never contribute to a later match.
  - The first possible pulse comes len beats after the load or reset.
- len=MAX_LEN: the full-width compare is active; fill saturates and stays ≥ len.
- Counter saturation: at the maximum value it holds, and out still pulses.

## Structure
- Shared package seq_det_pkg:
  - LEN_W computation (clog2 function)
  - default pattern, length and overlap constants
  - the len-to-mask function
- One sub-module: seq_det_sat_cnt, a parametrised saturating up-counter with synchronous active-low reset, synchronous clear and increment enable. It implements match_cnt.
- The rest is flat: the config register, shifter/fill, and compare/output register.

## Test plan
- Defaults after reset; drive 1,1,1,0,0,1,0 on consecutive in_vld cycles -> out=1 for one cycle after the 7th beat only; match_cnt=1; state=7 (overlap mode).
- cfg_pat=3'b101, len=3, ovl=1; stream 1,0,1,0,1 -> pulses after beats 3 and 5, match_cnt=2. Repeat with ovl=0 -> single pulse after beat 3, match_cnt=1, state=2 at end.
- Default pattern with in_vld=0 for 3 cycles between every beat -> one pulse after the 7th valid beat; out=0 during all gaps.
- CNT_W=2, pattern 2'b11, ovl=1; stream eight 1s -> pulses after beats 2..8 (7 pulses); match_cnt stops at 3.
- Mid-stream disturbance:
  - Send 1,1,1,0,0,1, then pulse rst_n=0 for one cycle, then send 0 -> no pulse; state=1.
  - Repeat the same stream with cfg_we (same pattern) asserted alongside in_vld at beat 4 -> beat dropped, no match, match_cnt=0.
- cfg_len=0 with any stream -> out never asserted. cfg_len=MAX_LEN+3 with pattern all-ones -> clamped; pulse after the 16th consecutive 1.
